// File: rtl/mem_arbiter_pkg.sv
// Shared defines for the memory arbiter and the cache blocks: default geometry,
// FSM state encoding and requester IDs.
package mem_arbiter_pkg;

  localparam int LINE_WIDTH_DEF  = 128;
  localparam int ADDR_WIDTH_DEF  = 32;
  localparam int MEM_LATENCY_DEF = 5;
  localparam int CNT_WIDTH       = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY_IC = 2'd1,
    ST_BUSY_DC = 2'd2,
    ST_RESP    = 2'd3
  } arb_state_t;

  typedef enum logic {
    REQ_IC = 1'b0,
    REQ_DC = 1'b1
  } req_id_t;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates iCache and dCache line requests onto a single fixed-latency memory port.
// MEM_ARB_RR_EN: when defined, simultaneous requests are round-robin; otherwise dCache wins.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int LINE_WIDTH  = LINE_WIDTH_DEF,
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int MEM_LATENCY = MEM_LATENCY_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ic_req,
  input  logic [ADDR_WIDTH-1:0] ic_addr,
  output logic [LINE_WIDTH-1:0] ic_data,
  output logic                  ic_data_ready,
  input  logic                  dc_req,
  input  logic                  dc_wr,
  input  logic [ADDR_WIDTH-1:0] dc_addr,
  input  logic [LINE_WIDTH-1:0] dc_wdata,
  output logic [LINE_WIDTH-1:0] dc_data,
  output logic                  dc_data_ready,
  output logic                  mem_req,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic [LINE_WIDTH-1:0] mem_rdata,
  output arb_state_t            state_dbg
);

  // Handshake: a requester raises *_req and holds it; the arbiter answers with a
  // one-cycle *_data_ready pulse, after which the requester may drop or re-raise req.
  localparam int                    OFFSET_BITS = $clog2(LINE_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK  = {ADDR_WIDTH{1'b1}} << OFFSET_BITS;
  localparam logic [CNT_WIDTH-1:0]  CNT_LOAD    = CNT_WIDTH'(MEM_LATENCY - 1);

  arb_state_t            state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  req_id_t               gnt_q, pick;
  logic                  grant;
  logic                  wr_q;
  logic                  last_beat;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LINE_WIDTH-1:0] wdata_q, ic_data_q, dc_data_q;

`ifdef MEM_ARB_RR_EN
  logic prefer_dc_q;
`endif

  always_comb begin
    pick = REQ_DC;
    if (ic_req && dc_req) begin
`ifdef MEM_ARB_RR_EN
      pick = prefer_dc_q ? REQ_DC : REQ_IC;
`else
      pick = REQ_DC;
`endif
    end else if (ic_req) begin
      pick = REQ_IC;
    end
  end

  assign grant     = (state_q == ST_IDLE) && (ic_req || dc_req);
  assign last_beat = (state_q == ST_BUSY_IC || state_q == ST_BUSY_DC) && (cnt_q == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    mem_req       = 1'b0;
    mem_wr        = 1'b0;
    ic_data_ready = 1'b0;
    dc_data_ready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant) begin
          state_d = (pick == REQ_DC) ? ST_BUSY_DC : ST_BUSY_IC;
          cnt_d   = CNT_LOAD;
        end
      end
      ST_BUSY_IC, ST_BUSY_DC: begin
        mem_req = 1'b1;
        mem_wr  = (state_q == ST_BUSY_DC) && wr_q;
        if (cnt_q == '0) state_d = ST_RESP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_RESP: begin
        ic_data_ready = (gnt_q == REQ_IC);
        dc_data_ready = (gnt_q == REQ_DC);
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Request attributes are frozen at the grant edge so the requester may drop req early.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt_q   <= REQ_DC;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (grant) begin
      gnt_q   <= pick;
      wr_q    <= (pick == REQ_DC) && dc_wr;
      addr_q  <= ((pick == REQ_DC) ? dc_addr : ic_addr) & ALIGN_MASK;
      wdata_q <= dc_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ic_data_q <= '0;
      dc_data_q <= '0;
    end else if (last_beat && !wr_q) begin
      if (gnt_q == REQ_IC) ic_data_q <= mem_rdata;
      else                 dc_data_q <= mem_rdata;
    end
  end

`ifdef MEM_ARB_RR_EN
  // After reset the pointer favours dCache; each grant hands priority to the other side.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      prefer_dc_q <= 1'b1;
    else if (grant) prefer_dc_q <= (pick == REQ_IC);
  end
`endif

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign ic_data   = ic_data_q;
  assign dc_data   = dc_data_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table of single transactions, tie arbitration,
// early request drop and mid-transaction reset, with a scoreboard of returned lines.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int LW  = 128;
  localparam int AW  = 32;
  localparam int LAT = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          ic_req, dc_req, dc_wr;
  logic [AW-1:0] ic_addr, dc_addr, mem_addr;
  logic [LW-1:0] ic_data, dc_data, dc_wdata, mem_wdata, mem_rdata;
  logic          ic_data_ready, dc_data_ready, mem_req, mem_wr;
  arb_state_t    state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  logic [LW:0]   exp_q[$];
  logic [LW-1:0] ic_model, dc_model;

  typedef struct {
    bit            is_dc;
    bit            wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
    logic [LW-1:0] rdata;
    logic [AW-1:0] exp_addr;
    bit            exp_wr;
  } vec_t;

  vec_t vecs[10];

  mem_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW), .MEM_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_data(ic_data), .ic_data_ready(ic_data_ready),
    .dc_req(dc_req), .dc_wr(dc_wr), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_data(dc_data), .dc_data_ready(dc_data_ready),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  always @(negedge clk) begin
    if (!reset) begin
      n_checks++;
      if (ic_data_ready && dc_data_ready) begin
        n_fail++;
        $display("FAIL both_ready: ic_data_ready=%0b dc_data_ready=%0b required not both 1",
                 ic_data_ready, dc_data_ready);
      end
    end
  end

  // ---------------- helpers / driver tasks ----------------
  task automatic check(input string name, input logic [LW:0] act, input logic [LW:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic sb_pop_check(input string name);
    logic [LW:0] exp;
    if (exp_q.size() == 0) begin
      check({name, "_sb_empty"}, 1, 0);
    end else begin
      exp = exp_q.pop_front();
      check(name, {dc_data_ready, dc_data_ready ? dc_data : ic_data}, exp);
    end
  endtask

  // Runs one transaction from an IDLE cycle; drop_at > 0 releases req at grant+drop_at.
  task automatic run_txn(input vec_t v, input int drop_at);
    int cyc = 0, mcnt = 0;
    bit got = 0;
    if (v.is_dc) begin
      dc_req = 1; dc_wr = v.wr; dc_addr = v.addr; dc_wdata = v.wdata;
    end else begin
      ic_req = 1; ic_addr = v.addr;
    end
    if (v.is_dc && v.wr) exp_q.push_back({1'b1, dc_model});
    else if (v.is_dc) begin dc_model = v.rdata; exp_q.push_back({1'b1, v.rdata}); end
    else begin ic_model = v.rdata; exp_q.push_back({1'b0, v.rdata}); end
    while (!got && cyc < 30) begin
      @(posedge clk); #1; cyc++;
      if (cyc == drop_at) begin ic_req = 0; dc_req = 0; end
      if (mem_req) begin
        mcnt++;
        if (mcnt == 1) begin
          check("mem_addr", LW'(mem_addr), LW'(v.exp_addr));
          check("mem_wr", LW'(mem_wr), LW'(v.exp_wr));
          if (v.exp_wr) check("mem_wdata", mem_wdata, v.wdata);
        end
        mem_rdata = (mcnt == LAT) ? v.rdata : rand_line();
      end
      if (ic_data_ready || dc_data_ready) got = 1;
    end
    check("ready_seen", got, 1);
    check("ready_latency", cyc, LAT + 1);
    check("mem_req_cycles", mcnt, LAT);
    check("ready_owner", {ic_data_ready, dc_data_ready}, {!v.is_dc, v.is_dc});
    if (got) sb_pop_check("line_data");
    if (v.is_dc) check("ic_data_kept", ic_data, ic_model);
    else         check("dc_data_kept", dc_data, dc_model);
    ic_req = 0; dc_req = 0;
    @(posedge clk); #1;
    check("ready_one_pulse", {ic_data_ready, dc_data_ready}, 0);
    check("back_idle", state_dbg, ST_IDLE);
  endtask

  task automatic wait_ready(output int cyc, output bit got);
    cyc = 0; got = 0;
    while (!got && cyc < 30) begin
      @(posedge clk); #1; cyc++;
      if (ic_data_ready || dc_data_ready) got = 1;
    end
  endtask

  task automatic tie_test();
    logic [LW-1:0] line = rand_line();
    bit order[$];
    int cyc;
    bit got;
`ifdef MEM_ARB_RR_EN
    order = '{1'b1, 1'b0, 1'b1};
`else
    order = '{1'b1, 1'b0};
`endif
    foreach (order[i]) exp_q.push_back({order[i], line});
    mem_rdata = line;
    ic_addr = 32'h0000_2000; dc_addr = 32'h0000_3000; dc_wr = 0;
    ic_req = 1; dc_req = 1;
    for (int k = 0; k < order.size(); k++) begin
      wait_ready(cyc, got);
      check("tie_ready_seen", got, 1);
      check("tie_spacing", cyc, (k == 0) ? LAT + 1 : LAT + 2);
      check("tie_owner", {ic_data_ready, dc_data_ready}, {!order[k], order[k]});
      if (got) sb_pop_check("tie_data");
`ifndef MEM_ARB_RR_EN
      dc_req = 0;
`endif
    end
    ic_req = 0; dc_req = 0;
    ic_model = line; dc_model = line;
    @(posedge clk); #1;
  endtask

  // ---------------- test ----------------
  initial begin
    int cyc, rdy_cnt;
    reset = 1; ic_req = 0; dc_req = 0; dc_wr = 0;
    ic_addr = '0; dc_addr = '0; dc_wdata = '0; mem_rdata = '0;
    ic_model = '0; dc_model = '0;

    vecs[0] = '{0, 0, 32'h0000_0053, '0, {4{32'h1111_2222}}, 32'h0000_0050, 0};
    vecs[1] = '{1, 1, 32'hFFFF_FFC4, {16{8'hA5}}, '0, 32'hFFFF_FFC0, 1};
    vecs[2] = '{1, 0, 32'h0000_1238, '0, {4{32'hDEAD_BEEF}}, 32'h0000_1230, 0};
    vecs[3] = '{0, 0, 32'h8000_000F, '0, {4{32'h0F0F_1234}}, 32'h8000_0000, 0};
    vecs[4] = '{1, 1, 32'h0000_0010, rand_line(), '0, 32'h0000_0010, 1};
    vecs[5] = '{1, 0, 32'h7FFF_FFFF, '0, {4{32'hCAFE_F00D}}, 32'h7FFF_FFF0, 0};
    for (int i = 6; i < 10; i++) begin
      vecs[i].is_dc    = $urandom_range(0, 1);
      vecs[i].wr       = vecs[i].is_dc && ($urandom_range(0, 1) == 1);
      vecs[i].addr     = $urandom;
      vecs[i].wdata    = rand_line();
      vecs[i].rdata    = rand_line();
      vecs[i].exp_addr = vecs[i].addr & 32'hFFFF_FFF0;
      vecs[i].exp_wr   = vecs[i].wr;
    end

    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_wr", mem_wr, 0);
    check("rst_mem_addr", LW'(mem_addr), 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_ready", {ic_data_ready, dc_data_ready}, 0);
    check("rst_ic_data", ic_data, 0);
    check("rst_dc_data", dc_data, 0);
    check("rst_state", state_dbg, ST_IDLE);
    reset = 0;
    @(posedge clk); #1;

    tie_test();

    for (int i = 0; i < 10; i++) run_txn(vecs[i], 0);

    run_txn('{0, 0, 32'h0000_0A07, '0, rand_line(), 32'h0000_0A00, 0}, 2);

    // Reset three edges after a grant must abort without a ready pulse.
    ic_req = 1; ic_addr = 32'h0000_0040;
    @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    check("pre_reset_busy", mem_req, 1);
    reset = 1;
    #1;
    check("reset_mem_req", mem_req, 0);
    check("reset_ready", {ic_data_ready, dc_data_ready}, 0);
    check("reset_state", state_dbg, ST_IDLE);
    check("reset_ic_data", ic_data, 0);
    ic_req = 0;
    ic_model = '0; dc_model = '0;
    @(posedge clk); #1;
    reset = 0;
    rdy_cnt = 0;
    for (cyc = 0; cyc < 10; cyc++) begin
      @(posedge clk); #1;
      if (ic_data_ready || dc_data_ready || mem_req) rdy_cnt++;
    end
    check("no_activity_after_abort", rdy_cnt, 0);
    run_txn('{1, 0, 32'h0000_0123, '0, rand_line(), 32'h0000_0120, 0}, 0);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
